boot_loader: RTL and testbench
==============================

# boot_loader

Byte-stream boot loader that fills instruction/data memory before the core runs. It sits upstream of `slave_wrapper`'s boot write port (`boot_wr_en`/`boot_wr_addr`/`boot_wr_data`) and is fed by a byte source such as a UART receiver. It parses one framed image, writes the payload bytes to consecutive addresses and verifies a checksum. It holds the core in reset through `core_hold` until a valid image has landed.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of the first payload byte.
- `MAX_LEN`, 4096, largest legal payload length in bytes (≤ 65535).
- `TIMEOUT_CYCLES`, 1_000_000, maximum idle gap between bytes inside a frame.
- `clk` in 1: system clock; the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: byte available.
- `rx_data` in 8: byte value.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `boot_wr_en` out 1: one-cycle memory byte write strobe.
- `boot_wr_addr` out 32: write byte address.
- `boot_wr_data` out 8: write byte.
- `core_hold` out 1: high keeps the core in reset; ORed into the core reset path by the SoC top.
- `boot_done` out 1: sticky; the image was loaded and verified.
- `boot_err` out 1: last frame failed.

## Operation
- Frame format: `0xA5` sync, LEN[7:0], LEN[15:8], LEN payload bytes, CSUM. CSUM = 8-bit wrap-around sum of the payload bytes.
- A byte is accepted when `rx_valid && rx_ready`. `rx_ready` is high in every state except DONE.
- States and transitions:
  - IDLE: non-`0xA5` bytes are discarded. `0xA5` clears `boot_err` and moves to LEN_LO.
  - LEN_LO → LEN_HI.
  - LEN_HI: LEN > MAX_LEN goes to ERR. LEN == 0 goes directly to CSUM. Otherwise goes to DATA.
  - DATA: each byte i (0-based) is written to BASE_ADDR + i and added to a running sum. The index is 16 bits, and the address is BASE_ADDR + zero-extended index. After byte LEN-1, go to CSUM.
  - CSUM: a match goes to DONE; a mismatch goes to ERR.
  - DONE: terminal until reset. `boot_done`=1, `core_hold`=0, `rx_ready`=0.
  - ERR: `boot_err`=1 and the state returns to IDLE the next cycle. `boot_err` stays high until the next accepted sync byte. Memory already written is not rolled back, and `core_hold` stays 1.
- Timeout: in LEN_LO/LEN_HI/DATA/CSUM, TIMEOUT_CYCLES consecutive cycles without an accepted byte → ERR. The idle counter clears on every accepted byte and on every state entry.
- The running sum and byte index clear on entry to LEN_LO.
- Reset mid-frame: everything returns to reset values, and the partial image is abandoned.

## Timing
- Reset values: state IDLE, `rx_ready`=1, `boot_wr_en`=0, `boot_wr_addr`=0, `boot_wr_data`=0, `core_hold`=1, `boot_done`=0, `boot_err`=0.
- Write latency: for a byte accepted in cycle N, `boot_wr_en`=1 in cycle N+1 with its address and data registered. Throughput is one byte per cycle with no bubbles.
- DONE is entered the cycle after the CSUM byte is accepted. `core_hold` falls and `boot_done` rises in that same cycle, which is at least one cycle after the last `boot_wr_en`.
- ERR is entered the cycle after the offending byte, or after the cycle in which the timeout count reaches TIMEOUT_CYCLES.
- All outputs are registered except `rx_ready`, which is a decode of the state register.

## Structure
- Package `boot_pkg` holds:
  - the `boot_state_e` enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR);
  - the `BOOT_SYNC` = 8'hA5 constant;
  - the `BOOT_LEN_W` = 16 constant.
- Sub-module `boot_timeout_ctr` holds the idle-gap counter: inputs clear and enable, output expired; width is $clog2(TIMEOUT_CYCLES+1).
- The FSM, address/index counter and checksum accumulator live in `boot_loader`.

## Test plan
- Valid image: send A5 04 00 11 22 33 44 AA back-to-back.
  - Required: four writes to 0x0,0x1,0x2,0x3 with data 11,22,33,44, one per cycle, each one cycle after acceptance.
  - Required: `boot_done`=1 and `core_hold`=0, `rx_ready`=0 thereafter.
- Bad checksum: send A5 02 00 01 02 04.
  - Required: two writes, then `boot_err`=1 and `core_hold`=1.
  - Required: a following A5 01 00 7F 7F clears `boot_err`, writes 0x7F at 0x0, and reaches DONE.
- Length checks, with MAX_LEN=16:
  - A5 11 00 → ERR with no writes.
  - A5 00 00 00 → DONE with no writes.
- Garbage before sync: send 00 FF 5A, then a valid frame.
  - Required: the leading bytes produce no writes, and the frame loads normally.
- Timeout, with TIMEOUT_CYCLES=8:
  - Send A5 03 00 10, then no bytes for 8 cycles.
  - Required: ERR after exactly 8 idle cycles, one write done, `core_hold` still 1.
- Reset mid-frame: assert `reset` low during DATA.
  - Required: outputs return to reset values immediately (asynchronously), with no further writes.
  - Required: a fresh frame after release loads from BASE_ADDR.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the byte-stream boot loader.
package boot_pkg;

  localparam int         BOOT_LEN_W = 16;
  localparam logic [7:0] BOOT_SYNC  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } boot_state_e;

  // States in which an idle gap between bytes counts towards the timeout.
  function automatic logic is_timed(boot_state_e s);
    return s inside {LEN_LO, LEN_HI, DATA, CSUM};
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input handshake plus the memory boot write port.
interface boot_loader_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        boot_wr_en;
  logic [31:0] boot_wr_addr;
  logic [7:0]  boot_wr_data;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, boot_wr_en, boot_wr_addr, boot_wr_data
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, boot_wr_en, boot_wr_addr, boot_wr_data
  );

endinterface

// File: rtl/boot_timeout_ctr.sv
// Idle-gap down-counter; expired pulses on the enabled cycle that reaches TIMEOUT_CYCLES.
module boot_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/boot_loader.sv
// Parses one framed boot image, writes its payload to memory and verifies the checksum.
//
//   state  | meaning
//   IDLE   | discard bytes until sync 0xA5
//   LEN_LO | expect length low byte
//   LEN_HI | expect length high byte, range-check length
//   DATA   | write payload bytes, accumulate sum
//   CSUM   | compare checksum byte
//   DONE   | image verified, core released, input closed
//   ERR    | frame failed, flag error, back to IDLE
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_LEN        = 4096,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  boot_loader_if.slave        bus,
  output logic                core_hold,
  output logic                boot_done,
  output logic                boot_err
);

  localparam logic [BOOT_LEN_W-1:0] MAX_LEN_L = BOOT_LEN_W'(MAX_LEN);

  boot_state_e           state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [BOOT_LEN_W-1:0] len_q, len_d;
  logic [BOOT_LEN_W-1:0] idx_q, idx_d;
  logic [7:0]            sum_q, sum_d;
  logic                  wr_en_q, wr_en_d;
  logic [31:0]           wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  rx_ready;
  logic                  accept;
  logic [BOOT_LEN_W-1:0] len_rx;
  logic                  tmo_clr;
  logic                  tmo_en;
  logic                  tmo_expired;

  assign rx_ready = (state_q != DONE);
  assign accept   = bus.rx_valid && rx_ready;
  assign len_rx   = {bus.rx_data, len_lo_q};

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (accept && (bus.rx_data == BOOT_SYNC)) begin
          state_d = LEN_LO;
          err_d   = 1'b0;
          sum_d   = '0;
          idx_d   = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_lo_d = bus.rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_rx;
          if (len_rx > MAX_LEN_L)   state_d = ERR;
          else if (len_rx == '0)    state_d = CSUM;
          else                      state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + 32'(idx_q);
          wr_data_d = bus.rx_data;
          sum_d     = sum_q + bus.rx_data;
          idx_d     = idx_q + BOOT_LEN_W'(1);
          if (idx_q == len_q - BOOT_LEN_W'(1)) state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (bus.rx_data == sum_q) ? DONE : ERR;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (tmo_expired) state_d = ERR;

    // Status flags follow the state being entered so they line up with it.
    if (state_d == ERR) err_d = 1'b1;
    if (state_d == DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tmo_en  = is_timed(state_q) && !accept;
  assign tmo_clr = accept || (state_d != state_q) || !is_timed(state_q);

  boot_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  assign bus.rx_ready     = rx_ready;
  assign bus.boot_wr_en   = wr_en_q;
  assign bus.boot_wr_addr = wr_addr_q;
  assign bus.boot_wr_data = wr_data_q;
  assign core_hold        = hold_q;
  assign boot_done        = done_q;
  assign boot_err         = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: framing, checksum, length limits, timeout and reset.
module tb_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  logic core_hold, boot_done, boot_err;

  boot_loader_if bif ();

  boot_loader #(
    .BASE_ADDR      (BASE),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .core_hold (core_hold),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [7:0]  data;
    logic        hold;
  } ent_t;

  ent_t       acc_q[$];
  ent_t       wr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int         cyc   = 0;
  int         n_chk = 0;
  int         n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log accepted bytes and memory writes with the cycle they were seen in.
  always @(negedge clk) begin
    if (bif.rx_valid && bif.rx_ready)
      acc_q.push_back('{cyc, 32'h0, bif.rx_data, core_hold});
    if (bif.boot_wr_en)
      wr_q.push_back('{cyc, bif.boot_wr_addr, bif.boot_wr_data, core_hold});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    wr_q.delete();
  endtask

  task automatic send_q();
    foreach (tx_q[i]) begin
      bif.rx_valid = 1'b1;
      bif.rx_data  = tx_q[i];
      @(posedge clk);
      #1;
    end
    bif.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
  endtask

  // Writes must match exp_q at BASE+i, land one cycle after their byte was accepted, with core held.
  task automatic check_wrs(input string tag, input int pl_off);
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < wr_q.size()) begin
        check({tag, "_addr"}, wr_q[i].addr, BASE + 32'(i));
        check({tag, "_data"}, 32'(wr_q[i].data), 32'(exp_q[i]));
        check({tag, "_hold"}, 32'(wr_q[i].hold), 32'd1);
        if (pl_off + i < acc_q.size())
          check({tag, "_lat"}, 32'(wr_q[i].cyc), 32'(acc_q[pl_off + i].cyc + 1));
        else
          check({tag, "_nacc"}, 32'(acc_q.size()), 32'(pl_off + i + 1));
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    #1 reset = 1'b0;
    #2;
    check("rst_ready", 32'(bif.rx_ready),  32'd1);
    check("rst_wr_en", 32'(bif.boot_wr_en), 32'd0);
    check("rst_addr",  bif.boot_wr_addr,   32'd0);
    check("rst_data",  32'(bif.boot_wr_data), 32'd0);
    check("rst_hold",  32'(core_hold), 32'd1);
    check("rst_done",  32'(boot_done), 32'd0);
    check("rst_err",   32'(boot_err),  32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();

    // Valid image
    tx_q  = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_q();
    @(negedge clk);
    check("ok_done",  32'(boot_done), 32'd1);
    check("ok_hold",  32'(core_hold), 32'd0);
    check("ok_ready", 32'(bif.rx_ready), 32'd0);
    check("ok_err",   32'(boot_err), 32'd0);
    check("ok_nacc",  32'(acc_q.size()), 32'd8);
    check_wrs("ok", 3);

    // DONE ignores further input
    clear_logs();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'h55};
    send_q();
    repeat (2) @(negedge clk);
    check("done_nacc", 32'(acc_q.size()), 32'd0);
    check("done_nwr",  32'(wr_q.size()),  32'd0);
    check("done_stay", 32'(boot_done), 32'd1);

    // Bad checksum, then recovery
    do_reset();
    tx_q  = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h04};
    exp_q = '{8'h01, 8'h02};
    send_q();
    @(negedge clk);
    check("bad_err",  32'(boot_err),  32'd1);
    check("bad_hold", 32'(core_hold), 32'd1);
    check("bad_done", 32'(boot_done), 32'd0);
    check_wrs("bad", 3);
    repeat (3) @(negedge clk);
    check("bad_sticky", 32'(boot_err), 32'd1);
    @(posedge clk);
    #1;
    clear_logs();
    tx_q  = '{8'hA5, 8'h01, 8'h00, 8'h7F, 8'h7F};
    exp_q = '{8'h7F};
    send_q();
    @(negedge clk);
    check("rec_err",  32'(boot_err),  32'd0);
    check("rec_done", 32'(boot_done), 32'd1);
    check_wrs("rec", 3);

    // Length over MAX_LEN
    do_reset();
    tx_q = '{8'hA5, 8'h11, 8'h00};
    exp_q.delete();
    send_q();
    @(negedge clk);
    check("big_err",  32'(boot_err),  32'd1);
    check("big_hold", 32'(core_hold), 32'd1);
    check_wrs("big", 3);

    // Length exactly MAX_LEN
    do_reset();
    tx_q = '{8'hA5, 8'h10, 8'h00};
    exp_q.delete();
    for (int i = 1; i <= 16; i++) begin
      tx_q.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    tx_q.push_back(8'h88);
    send_q();
    @(negedge clk);
    check("max_done", 32'(boot_done), 32'd1);
    check("max_err",  32'(boot_err),  32'd0);
    check_wrs("max", 3);

    // Zero length
    do_reset();
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    exp_q.delete();
    send_q();
    @(negedge clk);
    check("zero_done", 32'(boot_done), 32'd1);
    check("zero_hold", 32'(core_hold), 32'd0);
    check_wrs("zero", 4);

    // Garbage before sync
    do_reset();
    tx_q  = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'hC0, 8'h0F, 8'hCF};
    exp_q = '{8'hC0, 8'h0F};
    send_q();
    @(negedge clk);
    check("garb_done", 32'(boot_done), 32'd1);
    check_wrs("garb", 6);

    // Timeout after 8 idle cycles
    do_reset();
    tx_q  = '{8'hA5, 8'h03, 8'h00, 8'h10};
    exp_q = '{8'h10};
    send_q();
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("tmo_early", 32'(boot_err), 32'd0);
    @(negedge clk);
    check("tmo_err",  32'(boot_err),  32'd1);
    check("tmo_hold", 32'(core_hold), 32'd1);
    check("tmo_done", 32'(boot_done), 32'd0);
    check_wrs("tmo", 3);

    // Reset in the middle of DATA
    do_reset();
    tx_q = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22};
    send_q();
    check("mid_wr_live", 32'(bif.boot_wr_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_wr_en", 32'(bif.boot_wr_en), 32'd0);
    check("mid_addr",  bif.boot_wr_addr, 32'd0);
    check("mid_data",  32'(bif.boot_wr_data), 32'd0);
    check("mid_hold",  32'(core_hold), 32'd1);
    check("mid_ready", 32'(bif.rx_ready), 32'd1);
    check("mid_err",   32'(boot_err), 32'd0);
    clear_logs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_nwr", 32'(wr_q.size()), 32'd0);
    clear_logs();
    tx_q  = '{8'hA5, 8'h02, 8'h00, 8'h33, 8'h44, 8'h77};
    exp_q = '{8'h33, 8'h44};
    send_q();
    @(negedge clk);
    check("fresh_done", 32'(boot_done), 32'd1);
    check_wrs("fresh", 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
